// File: rtl/lap_sequencer.sv
// lap_sequencer: race session controller (start/soft-start ramp, laps, line-lost fault).
// Build option LAP_BCD_EN: lap_count is shown as two BCD digits saturating at 8'h99.
module lap_sequencer #(
  parameter int unsigned DEBOUNCE     = 16,
  parameter int unsigned LOCKOUT      = 50_000_000,
  parameter int unsigned LOST_TIMEOUT = 25_000_000,
  parameter logic [11:0] RAMP_START   = 12'h400,
  parameter logic [11:0] RAMP_STEP    = 12'h010,
  parameter int unsigned RAMP_DIV     = 500_000,
  parameter logic [11:0] DUTY_MAX     = 12'h999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  circuit,
  input  logic        senzor_1,
  input  logic        senzor_3,
  input  logic        senzor_5,
  output logic        run_en,
  output logic [11:0] duty_cap,
  output logic [7:0]  lap_count,
  output logic        lap_pulse,
  output logic        finished,
  output logic        line_lost
);

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int LKW = $clog2(LOCKOUT + 1);
  localparam int LSW = $clog2(LOST_TIMEOUT + 1);
  localparam int RDW = $clog2(RAMP_DIV + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DEBOUNCE);
  localparam logic [LKW-1:0] LK_LOAD = LKW'(LOCKOUT);
  localparam logic [LSW-1:0] LS_LAST = LSW'(LOST_TIMEOUT - 1);
  localparam logic [LSW-1:0] LS_MAX  = LSW'(LOST_TIMEOUT);
  localparam logic [RDW-1:0] RD_LAST = RDW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, RAMP, RUN, DONE, FAULT
  } state_t;

  state_t state, state_n;

  logic [1:0] start_ff, s1_ff, s3_ff, s5_ff;
  logic       start_d;
  logic       start_edge;
  logic       mark_hi, mark_lo, on_line;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_ff <= '0;
      s1_ff    <= '0;
      s3_ff    <= '0;
      s5_ff    <= '0;
      start_d  <= 1'b0;
    end else begin
      start_ff <= {start_ff[0], start};
      s1_ff    <= {s1_ff[0], senzor_1};
      s3_ff    <= {s3_ff[0], senzor_3};
      s5_ff    <= {s5_ff[0], senzor_5};
      start_d  <= start_ff[1];
    end
  end

  assign start_edge = start_ff[1] & ~start_d;
  assign mark_hi    = s1_ff[1] & s5_ff[1];
  assign mark_lo    = ~s1_ff[1] & ~s5_ff[1];
  assign on_line    = s3_ff[1];

  logic           active;
  logic [DBW-1:0] deb_cnt;
  logic [LKW-1:0] lock_cnt;
  logic [LSW-1:0] lost_cnt;
  logic [RDW-1:0] ramp_cnt;
  logic           armed;
  logic [7:0]     lap_bin;
  logic [7:0]     tgt_laps;
  logic           tgt_en;
  logic           lap_hit, tgt_hit, lost_hit, ramp_tick;
  logic [12:0]    duty_sum;
  logic [11:0]    duty_step, duty_n;

  assign active    = (state == RAMP) || (state == RUN);
  assign lap_hit   = active & armed & mark_hi & (deb_cnt == DB_LAST);
  assign tgt_hit   = tgt_en & (lap_bin == tgt_laps);
  assign lost_hit  = active & ~on_line & (lost_cnt == LS_LAST);
  assign ramp_tick = (state == RAMP) & (ramp_cnt == RD_LAST);
  assign duty_sum  = {1'b0, duty_cap} + {1'b0, RAMP_STEP};
  assign duty_step = (duty_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX
                                                    : duty_sum[11:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    duty_n  = duty_cap;
    unique case (state)
      IDLE: begin
        duty_n = '0;
        if (start_edge && circuit != 2'b00) begin
          if (RAMP_START >= DUTY_MAX) begin
            state_n = RUN;
            duty_n  = DUTY_MAX;
          end else begin
            state_n = RAMP;
            duty_n  = RAMP_START;
          end
        end
      end
      RAMP: begin
        if (ramp_tick) begin
          duty_n = duty_step;
          if (duty_step == DUTY_MAX) state_n = RUN;
        end
      end
      RUN: duty_n = DUTY_MAX;
      DONE, FAULT: begin
        duty_n = '0;
        if (start_edge || circuit == 2'b00) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        duty_n  = '0;
      end
    endcase
    // abort beats lap target, which beats line-lost
    if (active) begin
      if (circuit == 2'b00) begin
        state_n = IDLE;
        duty_n  = '0;
      end else if (tgt_hit) begin
        state_n = DONE;
        duty_n  = '0;
      end else if (lost_hit) begin
        state_n = FAULT;
        duty_n  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_cap  <= '0;
      ramp_cnt  <= '0;
      deb_cnt   <= '0;
      lock_cnt  <= '0;
      lost_cnt  <= '0;
      armed     <= 1'b1;
      lap_bin   <= '0;
      lap_pulse <= 1'b0;
      tgt_laps  <= '0;
      tgt_en    <= 1'b0;
    end else begin
      duty_cap  <= duty_n;
      lap_pulse <= lap_hit & (state_n != IDLE);

      if (state == RAMP && !ramp_tick) ramp_cnt <= ramp_cnt + 1'b1;
      else                             ramp_cnt <= '0;

      if (state == IDLE && start_edge && circuit != 2'b00) begin
        tgt_en   <= (circuit != 2'b11);
        tgt_laps <= (circuit == 2'b01) ? 8'd1 : 8'd10;
      end

      if (!active) begin
        deb_cnt  <= '0;
        lock_cnt <= '0;
        lost_cnt <= '0;
        armed    <= 1'b1;
      end else begin
        if (!mark_hi)               deb_cnt <= '0;
        else if (deb_cnt != DB_MAX) deb_cnt <= deb_cnt + 1'b1;

        if (on_line)                 lost_cnt <= '0;
        else if (lost_cnt != LS_MAX) lost_cnt <= lost_cnt + 1'b1;

        // re-arm only once the lockout is over and the markers are clear
        if (lap_hit) begin
          armed    <= 1'b0;
          lock_cnt <= LK_LOAD;
        end else if (lock_cnt != '0) begin
          lock_cnt <= lock_cnt - 1'b1;
        end else if (!armed && mark_lo) begin
          armed <= 1'b1;
        end
      end

      if (state_n == IDLE)               lap_bin <= '0;
      else if (lap_hit && lap_bin != '1) lap_bin <= lap_bin + 1'b1;
    end
  end

`ifdef LAP_BCD_EN
  logic [7:0] lap_bcd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_bcd <= '0;
    end else if (state_n == IDLE) begin
      lap_bcd <= '0;
    end else if (lap_hit && lap_bcd != 8'h99) begin
      if (lap_bcd[3:0] == 4'd9) lap_bcd <= {lap_bcd[7:4] + 4'd1, 4'd0};
      else                      lap_bcd <= {lap_bcd[7:4], lap_bcd[3:0] + 4'd1};
    end
  end

  assign lap_count = lap_bcd;
`else
  assign lap_count = lap_bin;
`endif

  assign run_en    = active;
  assign finished  = (state == DONE);
  assign line_lost = (state == FAULT);

endmodule

// File: tb/tb_lap_sequencer.sv
// tb_lap_sequencer: directed vector table plus multi-cycle corner sequences.
// Expected lap_count values follow the LAP_BCD_EN build option.
module tb_lap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  circuit;
  logic        senzor_1, senzor_3, senzor_5;
  logic        run_en;
  logic [11:0] duty_cap;
  logic [7:0]  lap_count;
  logic        lap_pulse;
  logic        finished;
  logic        line_lost;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  lap_sequencer #(
    .DEBOUNCE(4), .LOCKOUT(20), .LOST_TIMEOUT(30), .RAMP_DIV(2),
    .RAMP_START(12'h990), .RAMP_STEP(12'h004), .DUTY_MAX(12'h999)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .circuit(circuit),
    .senzor_1(senzor_1), .senzor_3(senzor_3), .senzor_5(senzor_5),
    .run_en(run_en), .duty_cap(duty_cap), .lap_count(lap_count),
    .lap_pulse(lap_pulse), .finished(finished), .line_lost(line_lost)
  );

`ifdef LAP_BCD_EN
  localparam logic [7:0] LAP10  = 8'h10;
  localparam logic [7:0] LAP42  = 8'h42;
  localparam logic [7:0] LAPSAT = 8'h99;
`else
  localparam logic [7:0] LAP10  = 8'h0A;
  localparam logic [7:0] LAP42  = 8'h2A;
  localparam logic [7:0] LAPSAT = 8'hFF;
`endif

  typedef struct {
    logic        st;
    logic [1:0]  circ;
    logic        s1, s3, s5;
    int          cyc;
    logic        run;
    logic [11:0] duty;
    logic [7:0]  lap;
    logic        pulse;
    logic        fin;
    logic        lost;
  } vec_t;

  vec_t tbl [18];

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pulse_cnt += int'(lap_pulse);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic run,
                         input logic [11:0] duty, input logic [7:0] lap,
                         input logic pulse, input logic fin,
                         input logic lost);
    chk({nm, ".run_en"}, 32'(run_en), 32'(run));
    chk({nm, ".duty_cap"}, 32'(duty_cap), 32'(duty));
    chk({nm, ".lap_count"}, 32'(lap_count), 32'(lap));
    chk({nm, ".lap_pulse"}, 32'(lap_pulse), 32'(pulse));
    chk({nm, ".finished"}, 32'(finished), 32'(fin));
    chk({nm, ".line_lost"}, 32'(line_lost), 32'(lost));
  endtask

  task automatic set_marks(input logic v);
    senzor_1 = v;
    senzor_5 = v;
  endtask

  task automatic start_session(input logic [1:0] c);
    circuit = c;
    start = 1'b1;
    run_cycles(3);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    circuit = 2'b00;
    senzor_1 = 1'b0;
    senzor_3 = 1'b1;
    senzor_5 = 1'b0;
    run_cycles(3);
    chk_all("reset", 0, 12'h000, 8'h00, 0, 0, 0);
    rst_n = 1'b1;
    run_cycles(3);

    // ramp 990,994,998,999; RUN; ignored start; short burst; lap; lockout
    tbl[0]  = '{0, 2'b10, 0, 1, 0, 2, 0, 12'h000, 8'd0, 0, 0, 0};
    tbl[1]  = '{1, 2'b10, 0, 1, 0, 3, 1, 12'h990, 8'd0, 0, 0, 0};
    tbl[2]  = '{1, 2'b10, 0, 1, 0, 1, 1, 12'h990, 8'd0, 0, 0, 0};
    tbl[3]  = '{0, 2'b10, 0, 1, 0, 1, 1, 12'h994, 8'd0, 0, 0, 0};
    tbl[4]  = '{0, 2'b10, 0, 1, 0, 2, 1, 12'h998, 8'd0, 0, 0, 0};
    tbl[5]  = '{0, 2'b10, 0, 1, 0, 2, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[6]  = '{0, 2'b10, 0, 1, 0, 5, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[7]  = '{1, 2'b10, 0, 1, 0, 4, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[8]  = '{0, 2'b10, 0, 1, 0, 2, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[9]  = '{0, 2'b10, 1, 1, 1, 3, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[10] = '{0, 2'b10, 0, 1, 0, 4, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[11] = '{0, 2'b10, 1, 1, 1, 5, 1, 12'h999, 8'd0, 0, 0, 0};
    tbl[12] = '{0, 2'b10, 1, 1, 1, 1, 1, 12'h999, 8'd1, 1, 0, 0};
    tbl[13] = '{0, 2'b10, 1, 1, 1, 1, 1, 12'h999, 8'd1, 0, 0, 0};
    tbl[14] = '{0, 2'b10, 0, 1, 0, 3, 1, 12'h999, 8'd1, 0, 0, 0};
    tbl[15] = '{0, 2'b10, 1, 1, 1, 6, 1, 12'h999, 8'd1, 0, 0, 0};
    tbl[16] = '{0, 2'b10, 0, 1, 0, 4, 1, 12'h999, 8'd1, 0, 0, 0};
    tbl[17] = '{0, 2'b00, 0, 1, 0, 1, 0, 12'h000, 8'd0, 0, 0, 0};

    for (int i = 0; i < 18; i++) begin
      start    = tbl[i].st;
      circuit  = tbl[i].circ;
      senzor_1 = tbl[i].s1;
      senzor_3 = tbl[i].s3;
      senzor_5 = tbl[i].s5;
      run_cycles(tbl[i].cyc);
      chk_all($sformatf("vec%0d", i), tbl[i].run, tbl[i].duty,
              tbl[i].lap, tbl[i].pulse, tbl[i].fin, tbl[i].lost);
    end
    run_cycles(3);

    // curves: ten laps then DONE
    start_session(2'b10);
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_marks(1'b1);
      run_cycles(6);
      set_marks(1'b0);
      run_cycles(34);
      if (i == 8) begin
        chk("lap9.finished", 32'(finished), 32'd0);
        chk("lap9.run_en", 32'(run_en), 32'd1);
      end
    end
    chk("curves.pulses", 32'(pulse_cnt), 32'd10);
    chk_all("curves.done", 0, 12'h000, LAP10, 0, 1, 0);
    start = 1'b1;
    run_cycles(3);
    start = 1'b0;
    chk_all("done.exit", 0, 12'h000, 8'd0, 0, 0, 0);
    run_cycles(3);

    // line lost: 29 low survives, 30 low faults
    start_session(2'b01);
    run_cycles(10);
    senzor_3 = 1'b0;
    run_cycles(29);
    senzor_3 = 1'b1;
    run_cycles(5);
    chk_all("lost29", 1, 12'h999, 8'd0, 0, 0, 0);
    senzor_3 = 1'b0;
    run_cycles(30);
    senzor_3 = 1'b1;
    run_cycles(2);
    chk_all("lost30", 0, 12'h000, 8'd0, 0, 0, 1);
    start = 1'b1;
    run_cycles(3);
    start = 1'b0;
    chk_all("fault.exit", 0, 12'h000, 8'd0, 0, 0, 0);
    run_cycles(3);

    // abort mid-RAMP
    start_session(2'b01);
    chk("ramp.duty", 32'(duty_cap), 32'h990);
    circuit = 2'b00;
    run_cycles(1);
    chk_all("abort.ramp", 0, 12'h000, 8'd0, 0, 0, 0);
    run_cycles(3);

    // reset pulse mid-RUN
    start_session(2'b01);
    run_cycles(10);
    chk("run.duty", 32'(duty_cap), 32'h999);
    rst_n = 1'b0;
    run_cycles(1);
    chk_all("rst.midrun", 0, 12'h000, 8'd0, 0, 0, 0);
    rst_n = 1'b1;
    run_cycles(3);
    chk("rst.stays_idle", 32'(run_en), 32'd0);

    // lap target and line-lost timeout land on the same edge
    start_session(2'b01);
    run_cycles(10);
    senzor_3 = 1'b0;
    run_cycles(25);
    set_marks(1'b1);
    run_cycles(6);
    set_marks(1'b0);
    run_cycles(3);
    chk_all("simul", 0, 12'h000, 8'd1, 0, 1, 0);
    senzor_3 = 1'b1;
    circuit = 2'b00;
    run_cycles(1);
    chk("simul.exit", 32'(finished), 32'd0);
    run_cycles(3);

    // endurance: 300 laps, saturating count, never DONE
    start_session(2'b11);
    pulse_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      set_marks(1'b1);
      run_cycles(6);
      set_marks(1'b0);
      run_cycles(24);
      if (i == 41) chk("endur.lap42", 32'(lap_count), 32'(LAP42));
    end
    chk("endur.pulses", 32'(pulse_cnt), 32'd300);
    chk_all("endur.sat", 1, 12'h999, LAPSAT, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
